// File: rtl/scan_decoder_if.sv
// Bundles the scan_decoder control inputs and decoded outputs.
// master drives control and observes outputs; slave is the decoder side.
interface scan_decoder_if #(
    parameter int ADDR_WIDTH  = 2,
    parameter int DWELL_WIDTH = 8
);
  localparam int NUM_OUT = 1 << ADDR_WIDTH;

  logic                   enable;
  logic                   mode;
  logic [ADDR_WIDTH-1:0]  address;
  logic [DWELL_WIDTH-1:0] dwell;
  logic [NUM_OUT-1:0]     out;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic                   wrap;

  modport master (
    output enable, mode, address, dwell,
    input  out, cur_addr, wrap
  );

  modport slave (
    input  enable, mode, address, dwell,
    output out, cur_addr, wrap
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct and autonomous scan modes.
// Define SCAN_DECODER_BOUNCE_EN to make scan ping-pong between endpoints instead of wrapping.
module scan_decoder #(
    parameter int ADDR_WIDTH  = 2,
    parameter int DWELL_WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
    scan_decoder_if.slave bus
);
  localparam int NUM_OUT = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_OUT-1:0]     out_q, out_d;
  logic [ADDR_WIDTH-1:0]  cur_q, cur_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   wrap_q, wrap_d;
  // Set while a scan is in progress (possibly paused); cleared by direct mode or reset.
  logic                   armed_q, armed_d;

  logic [ADDR_WIDTH-1:0]  adv_addr;
  logic                   adv_wrap;
  logic [NUM_OUT-1:0]     sel;

`ifdef SCAN_DECODER_BOUNCE_EN
  logic                   dir_down_q, dir_down_d;
  logic                   adv_dir_down;

  always_comb begin
    if (dir_down_q) begin
      adv_addr     = cur_q - 1'b1;
      adv_wrap     = (adv_addr == '0);
      adv_dir_down = ~adv_wrap;
    end else begin
      adv_addr     = cur_q + 1'b1;
      adv_wrap     = (adv_addr == LAST_ADDR);
      adv_dir_down = adv_wrap;
    end
  end
`else
  always_comb begin
    adv_addr = cur_q + 1'b1;
    adv_wrap = (adv_addr == '0);
  end
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    wrap_d  = 1'b0;
`ifdef SCAN_DECODER_BOUNCE_EN
    dir_down_d = dir_down_q;
`endif
    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else if (!bus.mode) begin
      state_d = ST_DIRECT;
      cur_d   = bus.address;
      armed_d = 1'b0;
    end else begin
      state_d = ST_SCAN;
      if (!armed_q) begin
        cur_d   = '0;
        cnt_d   = bus.dwell;
        armed_d = 1'b1;
`ifdef SCAN_DECODER_BOUNCE_EN
        dir_down_d = 1'b0;
`endif
      end else if (state_q == ST_SCAN) begin
        // Resuming from a pause re-shows the frozen position before stepping again.
        if (cnt_q == '0) begin
          cur_d  = adv_addr;
          cnt_d  = bus.dwell;
          wrap_d = adv_wrap;
`ifdef SCAN_DECODER_BOUNCE_EN
          dir_down_d = adv_dir_down;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_sel
    assign sel[gi] = (cur_d == ADDR_WIDTH'(gi));
  end

  always_comb begin
    out_d = (state_d == ST_IDLE) ? '0 : sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      armed_q <= 1'b0;
`ifdef SCAN_DECODER_BOUNCE_EN
      dir_down_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      armed_q <= armed_d;
`ifdef SCAN_DECODER_BOUNCE_EN
      dir_down_q <= dir_down_d;
`endif
    end
  end

  assign bus.out      = out_q;
  assign bus.cur_addr = cur_q;
  assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Directed plus randomized bench for scan_decoder, checked against a step-index model.
module tb_scan_decoder;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int N  = 1 << AW;
`ifdef SCAN_DECODER_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  scan_decoder_if #(.ADDR_WIDTH(AW), .DWELL_WIDTH(DW)) bus ();
  scan_decoder #(.ADDR_WIDTH(AW), .DWELL_WIDTH(DW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: scan position is a function of how many advances happened since scan start.
  logic [N-1:0]  e_out;
  logic [AW-1:0] e_cur;
  logic          e_wrap;
  bit            m_armed, m_prev_scan;
  int            m_left, m_k;

  function automatic int pos_of(input int k);
    int p, period;
    if (!BOUNCE) return k % N;
    period = 2 * (N - 1);
    p = k % period;
    return (p < N) ? p : period - p;
  endfunction

  task automatic model_step();
    logic [N-1:0] one;
    int np;
    one    = 1;
    e_wrap = 1'b0;
    if (reset) begin
      e_out = '0; e_cur = '0; m_armed = 0; m_prev_scan = 0; m_left = 0; m_k = 0;
    end else if (!bus.enable) begin
      e_out = '0; m_prev_scan = 0;
    end else if (!bus.mode) begin
      e_cur = bus.address; e_out = one << bus.address; m_armed = 0; m_prev_scan = 0;
    end else begin
      if (!m_armed) begin
        m_k = 0; m_left = int'(bus.dwell); m_armed = 1;
      end else if (m_prev_scan) begin
        if (m_left == 0) begin
          m_k++;
          m_left = int'(bus.dwell);
          np = pos_of(m_k);
          e_wrap = BOUNCE ? (np == 0 || np == N - 1) : (np == 0);
        end else begin
          m_left--;
        end
      end
      e_cur = AW'(pos_of(m_k));
      e_out = one << e_cur;
      m_prev_scan = 1;
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    $display("%-10s rst=%0b en=%0b mode=%0b addr=%0d dwell=%0d | out=%b cur=%0d wrap=%0b", tag,
             reset, bus.enable, bus.mode, bus.address, bus.dwell, bus.out, bus.cur_addr, bus.wrap);
    checks++;
    assert (bus.out === e_out) else begin
      errors++; $error("FAIL %s out: got %b expected %b", tag, bus.out, e_out);
    end
    checks++;
    assert (bus.cur_addr === e_cur) else begin
      errors++; $error("FAIL %s cur_addr: got %0d expected %0d", tag, bus.cur_addr, e_cur);
    end
    checks++;
    assert (bus.wrap === e_wrap) else begin
      errors++; $error("FAIL %s wrap: got %b expected %b", tag, bus.wrap, e_wrap);
    end
    checks++;
    assert ($countones(bus.out) <= 1) else begin
      errors++; $error("FAIL %s onehot: got %b expected at most one bit", tag, bus.out);
    end
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] exp);
    checks++;
    assert (bus.out === exp) else begin
      errors++; $error("FAIL %s: got %b expected %b", tag, bus.out, exp);
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int first, wrap_at, nwrap, found;
    logic [N-1:0] one;
    one = 1;
    reset = 1'b1; bus.enable = 1'b0; bus.mode = 1'b0; bus.address = '0; bus.dwell = '0;

    // Reset then idle
    repeat (2) cycle("reset");
    reset = 1'b0;
    repeat (5) cycle("idle");
    expect_out("idle_out", '0);

    // Direct decode, one address per cycle
    bus.enable = 1'b1; bus.mode = 1'b0;
    for (int a = 0; a < N; a++) begin
      bus.address = AW'(a);
      cycle("direct");
      expect_out("direct_onehot", one << a);
    end
    bus.enable = 1'b0;
    cycle("direct_off");
    expect_out("direct_off", '0);

    // Scan with dwell=2: one wrap, a full pass after the first 0001
    bus.enable = 1'b1; bus.mode = 1'b1; bus.dwell = 8'd2;
    first = -1; wrap_at = -1; nwrap = 0;
    for (int i = 0; i < 16; i++) begin
      cycle("scan");
      if (first < 0 && bus.out === one) first = i;
      if (bus.wrap === 1'b1) begin
        nwrap++;
        if (wrap_at < 0) wrap_at = i;
      end
    end
    expect_int("scan_first_0001", first, 0);
    expect_int("scan_wrap_delay", wrap_at - first, N * 3);
    expect_int("scan_wrap_count", nwrap, 1);

    // Pause at 0100 with dwell=0, then resume
    bus.mode = 1'b0; bus.address = '0;
    cycle("direct");
    bus.mode = 1'b1; bus.dwell = 8'd0;
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      cycle("scan0");
      if (bus.out === (one << 2)) found = 1;
    end
    expect_int("pause_reach_0100", found, 1);
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle("paused");
      expect_out("paused_out", '0);
    end
    bus.enable = 1'b1;
    cycle("resume");
    expect_out("resume_pos", one << 2);
    cycle("resume");
    expect_out("resume_next", one << 3);

    // Mode switch and reset mid-scan
    bus.mode = 1'b0; bus.address = AW'(1);
    cycle("to_direct");
    expect_out("mode_to_direct", one << 1);
    bus.mode = 1'b1;
    cycle("rescan");
    expect_out("rescan_start", one);
    repeat (2) cycle("scan0");
    reset = 1'b1;
    cycle("reset_mid");
    expect_out("reset_mid_out", '0);
    reset = 1'b0;
    bus.enable = 1'b0;
    cycle("idle");

`ifdef SCAN_DECODER_BOUNCE_EN
    begin
      int exp_seq[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
      bus.enable = 1'b1; bus.mode = 1'b1; bus.dwell = 8'd0;
      for (int i = 0; i < 8; i++) begin
        cycle("bounce");
        expect_int("bounce_cur", int'(bus.cur_addr), exp_seq[i]);
        expect_int("bounce_wrap", int'(bus.wrap), (i == 3 || i == 6) ? 1 : 0);
      end
    end
`endif

    // Randomized segments: inputs held for a few cycles at a time
    for (int s = 0; s < 150; s++) begin
      int len;
      reset       = ($urandom % 40) == 0;
      bus.enable  = ($urandom % 6) != 0;
      bus.mode    = ($urandom % 5) != 0;
      bus.address = AW'($urandom);
      bus.dwell   = DW'($urandom % 4);
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++) cycle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
